// File: rtl/cdc_pkg.sv
// cdc_pkg: shared state encoding and sizing for the destination-side bus synchronizer port.
package cdc_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} dst_state_e;
    localparam int C_DST_BUF_DEPTH = 2;
endpackage

// File: rtl/cdc_fifo2.sv
// cdc_fifo2: two-entry register FIFO with 1-bit wrapping pointers and a 0..2 occupancy count.
module cdc_fifo2
    import cdc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem_q [C_DST_BUF_DEPTH];
    logic [W-1:0] mem_d [C_DST_BUF_DEPTH];
    logic         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign full  = count_q == 2'd2;
    assign empty = count_q == 2'd0;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/cdc_bus_dst_port.sv
// cdc_bus_dst_port: four-phase responder that captures synchronizer words into a 2-entry buffer
// and presents them on a valid/ready stream; a full buffer withholds dst_ack to stall the source.
module cdc_bus_dst_port
    import cdc_pkg::*;
#(
    parameter int C_SYNC_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic [C_SYNC_WIDTH-1:0] dst_out,
    input  logic                    dst_req,
    output logic                    dst_ack,
    output logic [C_SYNC_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy
);
    dst_state_e state_q, state_d;
    logic       push, full, empty;

    always_comb begin
        push    = (state_q == ST_IDLE) & dst_req & ~full;
        state_d = (state_q == ST_IDLE) ? (push ? ST_ACK : ST_IDLE) : (dst_req ? ST_ACK : ST_IDLE);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // ACK lasts until dst_req falls, so a single request is never captured twice
    assign dst_ack = state_q == ST_ACK;
    assign m_valid = ~empty;
    assign busy    = dst_ack | ~empty;

    cdc_fifo2 #(.W(C_SYNC_WIDTH)) u_buf (
        .clk  (clk),
        .arstn(arstn),
        .push (push),
        .pop  (m_valid & m_ready),
        .din  (dst_out),
        .dout (m_data),
        .full (full),
        .empty(empty)
    );
endmodule
